// File: rtl/ctrl_if_pkg.sv
// Shared pipeline-control definitions: FSM states, the bubble instruction
// and the program-counter / stall-counter widths.
package ctrl_if_pkg;

  localparam int PC_W    = 16;
  localparam int STALL_W = 4;

  localparam logic [PC_W-1:0] CTRL_NOP = 16'hBF00;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    STALL = 2'd2,
    FLUSH = 2'd3
  } ctrl_state_e;

endpackage

// File: rtl/ctrl_if_stall_cnt.sv
// Stall-length counter: loads N-1 on a stall trigger, counts down while
// stalling, and flags the last stall cycle (count == 1).
module ctrl_if_stall_cnt
  import ctrl_if_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               load,
  input  logic [STALL_W-1:0] load_val,
  input  logic               dec,
  output logic               done
);

  logic [STALL_W-1:0] cnt_r;

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_r <= '0;
    end else if (clr) begin
      cnt_r <= '0;
    end else if (load) begin
      cnt_r <= load_val;
    end else if (dec && (cnt_r != '0)) begin
      cnt_r <= cnt_r - 1'b1;
    end
  end

  assign done = (cnt_r == {{(STALL_W-1){1'b0}}, 1'b1});

endmodule

// File: rtl/ctrl_if.sv
// Instruction-fetch control: drives the instruction memory, feeds the
// decode stage's instruction register, and inserts stalls and branch bubbles.
module ctrl_if
  import ctrl_if_pkg::*;
#(
  parameter logic [PC_W-1:0] NOP = CTRL_NOP
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [STALL_W-1:0]  i_mem_data_access,
  input  logic                i_branch_taken,
  input  logic [PC_W-1:0]     i_branch_target,
  input  logic [PC_W-1:0]     i_imem_rdata,
  output logic [PC_W-1:0]     o_imem_addr,
  output logic                o_imem_en,
  output logic [PC_W-1:0]     o_ir_r,
  output logic                o_stall,
  output logic [1:0]          o_dbg_state
);

  // Handshake: o_stall is simply !o_imem_en; while low, the decode stage holds
  // and the memory keeps i_imem_rdata stable, so the pending word is not lost.

  ctrl_state_e     state, nxt_state;
  logic [PC_W-1:0] pc_r;
  logic            fresh_r;

  logic imem_en;
  logic ir_nop, ir_load;
  logic pc_inc, pc_branch;
  logic cnt_clr, cnt_load, cnt_dec, cnt_done;
  logic trig;

  // A stall request is only meaningful for the instruction just handed to decode.
  assign trig = (state == RUN) && fresh_r && (i_mem_data_access != '0);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= nxt_state;
    end
  end

  always_comb begin
    nxt_state = state;
    imem_en   = 1'b1;
    ir_nop    = 1'b0;
    ir_load   = 1'b0;
    pc_inc    = 1'b0;
    pc_branch = 1'b0;
    cnt_clr   = 1'b0;
    cnt_load  = 1'b0;
    cnt_dec   = 1'b0;
    if (i_branch_taken) begin
      nxt_state = FLUSH;
      ir_nop    = 1'b1;
      pc_branch = 1'b1;
      cnt_clr   = 1'b1;
    end else begin
      case (state)
        IDLE, FLUSH: begin
          nxt_state = RUN;
          ir_nop    = 1'b1;
          pc_inc    = 1'b1;
        end
        RUN: begin
          if (trig) begin
            imem_en   = 1'b0;
            cnt_load  = 1'b1;
            nxt_state = (i_mem_data_access > 4'd1) ? STALL : RUN;
          end else begin
            ir_load = 1'b1;
            pc_inc  = 1'b1;
          end
        end
        STALL: begin
          imem_en = 1'b0;
          cnt_dec = 1'b1;
          if (cnt_done) begin
            nxt_state = RUN;
          end
        end
        default: nxt_state = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_r    <= '0;
      o_ir_r  <= NOP;
      fresh_r <= 1'b0;
    end else begin
      if (pc_branch) begin
        pc_r <= i_branch_target & ~16'h0001;
      end else if (pc_inc) begin
        pc_r <= pc_r + 16'd2;
      end
      if (ir_nop) begin
        o_ir_r <= NOP;
      end else if (ir_load) begin
        o_ir_r <= i_imem_rdata;
      end
      fresh_r <= ir_load;
    end
  end

  ctrl_if_stall_cnt u_stall_cnt (
    .clk      (clk),
    .rst      (rst),
    .clr      (cnt_clr),
    .load     (cnt_load),
    .load_val (i_mem_data_access - 4'd1),
    .dec      (cnt_dec),
    .done     (cnt_done)
  );

  assign o_imem_addr = pc_r;
  assign o_imem_en   = imem_en;
  assign o_stall     = !imem_en;
  assign o_dbg_state = state;

endmodule

// File: tb/tb_ctrl_if.sv
// Bench for ctrl_if: instruction memory model, behavioural fetch model checked
// every cycle, and directed vectors with hand-computed expectations.
module tb_ctrl_if;
  import ctrl_if_pkg::*;

  localparam logic [15:0] NOP = 16'hBF00;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  i_mem_data_access;
  logic        i_branch_taken;
  logic [15:0] i_branch_target;
  logic [15:0] i_imem_rdata = 16'h0000;
  logic [15:0] o_imem_addr;
  logic        o_imem_en;
  logic [15:0] o_ir_r;
  logic        o_stall;
  logic [1:0]  o_dbg_state;

  always #5 clk = ~clk;

  ctrl_if dut (
    .clk               (clk),
    .rst               (rst),
    .i_mem_data_access (i_mem_data_access),
    .i_branch_taken    (i_branch_taken),
    .i_branch_target   (i_branch_target),
    .i_imem_rdata      (i_imem_rdata),
    .o_imem_addr       (o_imem_addr),
    .o_imem_en         (o_imem_en),
    .o_ir_r            (o_ir_r),
    .o_stall           (o_stall),
    .o_dbg_state       (o_dbg_state)
  );

  // Instruction memory: word w holds 0x1000 + w, except words 0 and 1.
  logic [15:0] mem [0:32767];
  initial begin
    for (int w = 0; w < 32768; w++) mem[w] = 16'h1000 + 16'(w);
    mem[0] = 16'h2001;
    mem[1] = 16'h2102;
  end

  always @(posedge clk) begin
    if (o_imem_en) i_imem_rdata <= mem[o_imem_addr[15:1]];
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Tracks: where the PC is, what decode holds, how many further stall cycles
  // remain, whether decode's instruction is new, and which address was last read.
  bit          m_valid = 0;
  bit          m_run   = 0;
  bit          m_fresh = 0;
  int          m_left  = 0;
  logic [15:0] m_pc    = 16'h0000;
  logic [15:0] m_ir    = 16'h0000;
  logic [15:0] m_fetch = 16'h0000;

  always @(negedge clk) begin
    bit          trig, exp_stall;
    logic [15:0] data;
    trig      = m_run && (m_left == 0) && m_fresh && (i_mem_data_access != 4'd0);
    exp_stall = m_run && ((m_left > 0) || trig) && !i_branch_taken;
    if (m_valid) begin
      check("model_addr",  o_imem_addr, m_pc);
      check("model_ir",    o_ir_r, m_ir);
      check("model_stall", 16'(o_stall), 16'(exp_stall));
      check("model_en",    16'(o_imem_en), 16'(!exp_stall));
    end
    data = mem[m_fetch[15:1]];
    if (!exp_stall) m_fetch = m_pc;
    if (!rst) begin
      m_valid = 1; m_run = 0; m_fresh = 0; m_left = 0;
      m_pc = 16'h0000; m_ir = NOP;
    end else if (i_branch_taken) begin
      m_pc = i_branch_target & 16'hFFFE; m_ir = NOP;
      m_left = 0; m_fresh = 0; m_run = 0;
    end else if (!m_run) begin
      m_ir = NOP; m_pc = m_pc + 16'd2; m_run = 1; m_fresh = 0;
    end else if (m_left > 0) begin
      m_left--; m_fresh = 0;
    end else if (trig) begin
      m_left = int'(i_mem_data_access) - 1; m_fresh = 0;
    end else begin
      m_ir = data; m_pc = m_pc + 16'd2; m_fresh = 1;
    end
  end

  // ---------------- driver ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic [3:0] n, input logic b, input logic [15:0] t);
    rst               = r;
    i_mem_data_access = n;
    i_branch_taken    = b;
    i_branch_target   = t;
  endtask

  task automatic expect3(input string tag, input logic [15:0] addr, input logic [15:0] ir,
                         input logic stall);
    @(negedge clk);
    check({tag, "_addr"},  o_imem_addr, addr);
    check({tag, "_ir"},    o_ir_r, ir);
    check({tag, "_stall"}, 16'(o_stall), 16'(stall));
  endtask

  initial begin
    int s_cnt;
    drive(0, 4'd0, 0, 16'h0000);
    repeat (3) @(posedge clk);
    #1;
    // Reset release and first fetches.
    drive(1, 4'd0, 0, 16'h0000);
    expect3("rst", 16'h0000, NOP, 0);
    check("rst_en", 16'(o_imem_en), 16'h0001);
    check("rst_state", 16'(o_dbg_state), 16'(IDLE));
    next_cycle(); expect3("boot1", 16'h0002, NOP, 0);
    next_cycle(); expect3("boot2", 16'h0004, 16'h2001, 0);
    next_cycle(); expect3("boot3", 16'h0006, 16'h2102, 0);
    // Two-cycle stall at pc 0x10, request held afterwards.
    repeat (5) next_cycle();
    drive(1, 4'd2, 0, 16'h0000);
    expect3("st2_c0", 16'h0010, 16'h1006, 1);
    next_cycle(); expect3("st2_c1", 16'h0010, 16'h1006, 1);
    next_cycle(); expect3("no_retrig", 16'h0010, 16'h1006, 0);
    // N=4 stall, branch (odd target) in the second STALL-state cycle.
    next_cycle(); drive(1, 4'd4, 0, 16'h0000);
    expect3("st4_c0", 16'h0012, 16'h1007, 1);
    next_cycle(); drive(1, 4'd0, 0, 16'h0000);
    expect3("st4_c1", 16'h0012, 16'h1007, 1);
    next_cycle(); drive(1, 4'd0, 1, 16'h0041);
    expect3("br_in_stall", 16'h0012, 16'h1007, 0);
    next_cycle(); drive(1, 4'd0, 0, 16'h0000);
    expect3("flush1", 16'h0040, NOP, 0);
    next_cycle(); expect3("flush2", 16'h0042, NOP, 0);
    // Stall request and branch together: branch wins.
    next_cycle(); drive(1, 4'd3, 1, 16'h0100);
    expect3("br_vs_stall", 16'h0044, 16'h1020, 0);
    check("br_vs_stall_en", 16'(o_imem_en), 16'h0001);
    next_cycle(); drive(1, 4'd0, 0, 16'h0000);
    expect3("bvs_flush1", 16'h0100, NOP, 0);
    check("bvs_state", 16'(o_dbg_state), 16'(FLUSH));
    next_cycle(); expect3("bvs_flush2", 16'h0102, NOP, 0);
    // PC wrap from 0xFFFE.
    next_cycle(); drive(1, 4'd0, 1, 16'hFFFC);
    expect3("bvs_target", 16'h0104, 16'h1080, 0);
    next_cycle(); drive(1, 4'd0, 0, 16'h0000);
    expect3("wrap_a", 16'hFFFC, NOP, 0);
    next_cycle(); expect3("wrap_b", 16'hFFFE, NOP, 0);
    next_cycle(); expect3("wrap_c", 16'h0000, 16'h8FFE, 0);
    // Reset in the middle of a stall; branch during reset is ignored.
    next_cycle(); drive(1, 4'd5, 0, 16'h0000);
    expect3("st5_c0", 16'h0002, 16'h8FFF, 1);
    next_cycle(); drive(1, 4'd0, 0, 16'h0000);
    expect3("st5_c1", 16'h0002, 16'h8FFF, 1);
    next_cycle(); drive(0, 4'd3, 0, 16'h0000);
    expect3("rst_in_stall", 16'h0002, 16'h8FFF, 1);
    next_cycle(); drive(0, 4'd0, 1, 16'h0200);
    expect3("rst_hold", 16'h0000, NOP, 0);
    next_cycle(); drive(1, 4'd0, 0, 16'h0000);
    expect3("rst_rel", 16'h0000, NOP, 0);
    check("rst_rel_state", 16'(o_dbg_state), 16'(IDLE));
    next_cycle(); expect3("rst_rel1", 16'h0002, NOP, 0);
    // N=1 stall: one cycle only, no re-trigger with the request held.
    next_cycle(); drive(1, 4'd1, 0, 16'h0000);
    expect3("st1_c0", 16'h0004, 16'h2001, 1);
    next_cycle(); expect3("st1_c1", 16'h0004, 16'h2001, 0);
    // N=15: count stall cycles.
    next_cycle(); drive(1, 4'd15, 0, 16'h0000);
    s_cnt = 0;
    @(negedge clk);
    if (o_stall) s_cnt++;
    for (int i = 1; i < 20; i++) begin
      next_cycle(); drive(1, 4'd0, 0, 16'h0000);
      @(negedge clk);
      if (o_stall) s_cnt++;
    end
    check("stall_len_15", 16'(s_cnt), 16'd15);
    // Random tail, checked by the model only.
    for (int i = 0; i < 400; i++) begin
      next_cycle();
      drive(($urandom_range(0, 59) != 0),
            ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'd0,
            ($urandom_range(0, 24) == 0),
            16'($urandom_range(0, 16'hFFFF)));
    end
    next_cycle(); drive(1, 4'd0, 0, 16'h0000);
    repeat (20) next_cycle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
